// File: rtl/sram_write_scoreboard.sv
// Write-bus monitor for one SRAM address region: coverage bitmap, duplicate and
// out-of-region counts, order-independent data signature, and an end-of-run unwritten sweep.
module sram_write_scoreboard #(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned REGION_LO = 146944,
    parameter int unsigned REGION_HI = 262143,
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned SIG_W     = 32
) (
    input  logic              Clock_50,
    input  logic              Reset,
    input  logic              SRAM_we_n,
    input  logic [ADDR_W-1:0] SRAM_address,
    input  logic [DATA_W-1:0] SRAM_write_data,
    input  logic              Sweep_start,
    input  logic              Restart,
    output logic              Ready,
    output logic              Done,
    output logic [CNT_W-1:0]  Write_count,
    output logic [CNT_W-1:0]  Out_of_region_count,
    output logic [CNT_W-1:0]  Duplicate_count,
    output logic [ADDR_W-1:0] First_duplicate_address,
    output logic [CNT_W-1:0]  Unwritten_count,
    output logic [ADDR_W-1:0] First_unwritten_address,
    output logic [SIG_W-1:0]  Signature,
    output logic              Lost_write
);

    localparam int unsigned DEPTH = REGION_HI - REGION_LO + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_MONITOR,
        ST_DRAIN,
        ST_SWEEP,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q;
    logic             ptr_last;
    logic             drain_q;
    logic             restart_go;

    logic              bitmap [DEPTH];

    logic              s1_valid_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [DATA_W-1:0] s1_data_q;
    logic              s1_in;
    logic [IDX_W-1:0]  s1_idx;
    logic              s1_hit;

    logic              s2_valid_q;
    logic              s2_in_q;
    logic              s2_hit_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic [DATA_W-1:0] s2_data_q;
    logic [IDX_W-1:0]  s2_idx_q;

    function automatic logic in_region(input logic [ADDR_W-1:0] a);
        return (32'(a) >= REGION_LO) && (32'(a) <= REGION_HI);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        ptr_last   = (ptr_q == IDX_W'(DEPTH - 1));
        restart_go = (state_q == ST_DONE) && Restart;
        case (state_q)
            ST_CLEAR:   if (ptr_last) state_d = ST_MONITOR;
            ST_MONITOR: if (Sweep_start) state_d = ST_DRAIN;
            ST_DRAIN:   if (drain_q) state_d = ST_SWEEP;
            ST_SWEEP:   if (ptr_last) state_d = ST_DONE;
            ST_DONE:    if (Restart) state_d = ST_MONITOR;
            default:    state_d = ST_CLEAR;
        endcase
    end

    // State register, walk pointer and status flags
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            drain_q <= 1'b0;
            Ready   <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == ST_DRAIN) && !drain_q;
            Ready   <= (state_d == ST_MONITOR);
            Done    <= (state_d == ST_DONE);
            if (state_q == ST_CLEAR || state_q == ST_SWEEP) begin
                ptr_q <= ptr_last ? '0 : ptr_q + IDX_W'(1);
            end else begin
                ptr_q <= '0;
            end
        end
    end

    // S1 lookup; the S2 forward covers a same-address write one cycle behind
    always_comb begin
        s1_in  = in_region(s1_addr_q);
        s1_idx = IDX_W'(s1_addr_q - ADDR_W'(REGION_LO));
        s1_hit = bitmap[s1_idx] || (s2_valid_q && s2_in_q && (s2_addr_q == s1_addr_q));
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_in_q    <= 1'b0;
            s2_hit_q   <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
            s2_idx_q   <= '0;
        end else begin
            s1_valid_q <= (state_q == ST_MONITOR) && !SRAM_we_n;
            s1_addr_q  <= SRAM_address;
            s1_data_q  <= SRAM_write_data;
            s2_valid_q <= s1_valid_q;
            s2_in_q    <= s1_in;
            s2_hit_q   <= s1_hit;
            s2_addr_q  <= s1_addr_q;
            s2_data_q  <= s1_data_q;
            s2_idx_q   <= s1_idx;
        end
    end

    // Coverage bitmap: cleared while walked in CLEAR/SWEEP, set by S2 otherwise
    always_ff @(posedge Clock_50) begin
        if (state_q == ST_CLEAR || state_q == ST_SWEEP) begin
            bitmap[ptr_q] <= 1'b0;
        end else if (s2_valid_q && s2_in_q) begin
            bitmap[s2_idx_q] <= 1'b1;
        end
    end

    // Result counters, captured addresses, signature and lost-write flag
    always_ff @(posedge Clock_50) begin
        if (Reset || restart_go) begin
            Write_count             <= '0;
            Out_of_region_count     <= '0;
            Duplicate_count         <= '0;
            First_duplicate_address <= '0;
            Unwritten_count         <= '0;
            First_unwritten_address <= '0;
            Signature               <= '0;
            Lost_write              <= 1'b0;
        end else begin
            if (s2_valid_q) begin
                if (!s2_in_q) begin
                    Out_of_region_count <= sat_inc(Out_of_region_count);
                end else begin
                    Write_count <= sat_inc(Write_count);
                    Signature   <= Signature + SIG_W'({s2_addr_q, s2_data_q});
                    if (s2_hit_q) begin
                        Duplicate_count <= sat_inc(Duplicate_count);
                        if (Duplicate_count == '0) First_duplicate_address <= s2_addr_q;
                    end
                end
            end
            if (state_q == ST_SWEEP && !bitmap[ptr_q]) begin
                Unwritten_count <= sat_inc(Unwritten_count);
                if (Unwritten_count == '0) begin
                    First_unwritten_address <= ADDR_W'(REGION_LO) + ADDR_W'(ptr_q);
                end
            end
            if (!SRAM_we_n && state_q != ST_MONITOR) Lost_write <= 1'b1;
        end
    end

endmodule

// File: doc/sram_write_scoreboard.md
Name: sram_write_scoreboard

Overview:
- Parametrised, synthesisable monitor on the SRAM write bus. Generalises the bench-side write checking (region violation, per-location write counting, unwritten-location sweep) into a block that runs alongside any milestone.
- Records per-address coverage in an internal bitmap for one configurable region, counts duplicates and out-of-region writes, and accumulates an order-independent data signature.
- At end of decode, a sweep counts unwritten locations.
- Sits in project beside the SRAM interface. Results feed LEDs/seven-seg or the UART.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- REGION_LO, 146944, first monitored address (inclusive).
- REGION_HI, 262143, last monitored address (inclusive). DEPTH = REGION_HI-REGION_LO+1.
- CNT_W, 20, width of all counters. Counters saturate at all-ones.
- SIG_W, 32, signature width.

Ports:
- Clock_50  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- SRAM_we_n  in  1  write strobe, active low; sampled every rising edge.
- SRAM_address  in  ADDR_W  write address.
- SRAM_write_data  in  DATA_W  write data.
- Sweep_start  in  1  one-cycle pulse; begin end-of-run sweep.
- Restart  in  1  one-cycle pulse; leave DONE and rearm.
- Ready  out  1  high only in MONITOR.
- Done  out  1  high only in DONE.
- Write_count  out  CNT_W  in-region writes.
- Out_of_region_count  out  CNT_W  writes outside [REGION_LO, REGION_HI].
- Duplicate_count  out  CNT_W  in-region writes to an already-written address.
- First_duplicate_address  out  ADDR_W  address of first duplicate.
- Unwritten_count  out  CNT_W  valid in DONE.
- First_unwritten_address  out  ADDR_W  lowest unwritten address; valid in DONE when Unwritten_count != 0.
- Signature  out  SIG_W  sum mod 2^SIG_W of in-region terms.
- Lost_write  out  1  sticky: a write was sampled outside MONITOR.

Behaviour:
- States: CLEAR, MONITOR, DRAIN, SWEEP, DONE.
- Reset:
  - Enters CLEAR.
  - All counters, addresses and Signature go to 0. Lost_write, Ready and Done go to 0.
  - Reset in any state (including mid-SWEEP) takes priority over all other inputs.
- CLEAR:
  - Clears one bitmap entry per cycle, REGION_LO upward, for DEPTH cycles, then enters MONITOR.
  - Writes sampled here set Lost_write and are otherwise ignored.
- MONITOR pipeline, 2 stages:
  - S1: sample the write. If outside the region, Out_of_region_count++ two cycles later; bitmap and Signature untouched. If in the region, read the bitmap bit.
  - S2: if bit set, Duplicate_count++ (capture First_duplicate_address when the count was 0). Set the bit, Write_count++, Signature += term.
  - term = lower SIG_W bits of the concatenation {address, data}, zero-extended.
  - Counter and Signature outputs are registered. They reflect a write 2 cycles after the edge that sampled it.
  - Back-to-back and 2-apart writes to the same address must be detected as duplicates via forwarding from S2 to S1, so no write is missed or double-counted at any write rate, including one write every cycle.
- Sweep_start in MONITOR:
  - Go to DRAIN for 2 cycles (pipeline empties; a write on the Sweep_start cycle is still processed), then SWEEP.
  - Sweep_start in other states is ignored.
- SWEEP:
  - Reads one bitmap bit per cycle, REGION_LO upward, for DEPTH cycles.
  - Each 0 increments Unwritten_count; the first 0 captures First_unwritten_address.
  - Each entry is cleared as read, so no separate CLEAR is needed afterwards.
  - Writes set Lost_write.
- DONE:
  - All results held stable. Writes set Lost_write.
  - Restart enters MONITOR next cycle and zeroes all counters, addresses, Signature and Lost_write.
  - Restart in other states is ignored.
- Total latency, Sweep_start to Done high: DEPTH+3 cycles.
- Saturation: at all-ones a counter stays there. Signature wraps mod 2^SIG_W.

Test Plan:
Small configuration for all scenarios: REGION_LO=16, REGION_HI=31, ADDR_W=18, DATA_W=16, SIG_W=32.
1. Reset -> Ready=0 for 16 cycles, then Ready=1; all outputs 0.
2. Write addresses 16..31 once each, then Sweep_start -> Done rises 19 cycles after Sweep_start; Write_count=16, Unwritten_count=0, Duplicate_count=0.
3. Writes (16,0x0001),(17,0x0002) only -> Signature=0x00210003 two cycles after the second write; after sweep Unwritten_count=14, First_unwritten_address=18.
4. Writes to 20 on consecutive cycles, then 20 again 2 cycles later, plus one write to address 5 -> Duplicate_count=2, First_duplicate_address=20, Write_count=3, Out_of_region_count=1, Signature excludes the address-5 write.
5. Write during SWEEP -> Lost_write=1, counts unaffected. Restart then replay scenario 2 -> identical results, Lost_write=0.
6. Reset asserted mid-SWEEP -> next cycle all outputs 0. CLEAR lasts 16 cycles, then Ready=1; a sweep with no writes gives Unwritten_count=16, First_unwritten_address=16.
